// File: rtl/ex_mem_fwd_if.sv
// rtl/ex_mem_fwd_if.sv - EX/MEM pipeline, store-buffer control and forwarding lookup bundle
interface ex_mem_fwd_if #(
   parameter int ADDR_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int ALUOP_W    = 8,
   parameter int SB_DEPTH   = 4
);
   localparam int CNT_W = $clog2(SB_DEPTH) + 1;

   // pipeline control
   logic [5:0]            stall;
   logic                  flush;
   logic                  sb_clear;

   // execute-stage side
   logic [31:0]           debug_pc_i;
   logic [REG_ADDR_W-1:0] ex_waddr;
   logic                  ex_we;
   logic [31:0]           ex_wdata;
   logic [ALUOP_W-1:0]    ex_aluop;
   logic [ADDR_W-1:0]     ex_mem_addr;
   logic [31:0]           ex_mem_data;
   logic                  ex_store_en;
   logic [1:0]            ex_store_size;

   // memory-stage side
   logic [31:0]           debug_pc_o;
   logic [REG_ADDR_W-1:0] mem_waddr;
   logic                  mem_we;
   logic [31:0]           mem_wdata;
   logic [ALUOP_W-1:0]    mem_aluop;
   logic [ADDR_W-1:0]     mem_mem_addr;
   logic [31:0]           mem_mem_data;

   // store-forwarding lookup
   logic [ADDR_W-1:0]     ld_addr;
   logic [31:0]           fwd_data;
   logic [3:0]            fwd_mask;
   logic                  fwd_hit;
   logic [CNT_W-1:0]      sb_count;

   modport slave (
      input  stall, flush, sb_clear,
      input  debug_pc_i, ex_waddr, ex_we, ex_wdata, ex_aluop,
      input  ex_mem_addr, ex_mem_data, ex_store_en, ex_store_size, ld_addr,
      output debug_pc_o, mem_waddr, mem_we, mem_wdata, mem_aluop,
      output mem_mem_addr, mem_mem_data, fwd_data, fwd_mask, fwd_hit, sb_count
   );

   modport master (
      output stall, flush, sb_clear,
      output debug_pc_i, ex_waddr, ex_we, ex_wdata, ex_aluop,
      output ex_mem_addr, ex_mem_data, ex_store_en, ex_store_size, ld_addr,
      input  debug_pc_o, mem_waddr, mem_we, mem_wdata, mem_aluop,
      input  mem_mem_addr, mem_mem_data, fwd_data, fwd_mask, fwd_hit, sb_count
   );
endinterface

// File: rtl/ex_mem_fwd.sv
// rtl/ex_mem_fwd.sv - EX/MEM pipeline register with store-history buffer and byte-lane store forwarding
module ex_mem_fwd #(
   parameter int ADDR_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int ALUOP_W    = 8,
   parameter int SB_DEPTH   = 4
) (
   input logic          clk,
   input logic          rst,
   ex_mem_fwd_if.slave  bus
);
   localparam int PTR_W = $clog2(SB_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int WA_W  = ADDR_W - 2;

   // capture decision: flush dominates, then EX-stalled-but-MEM-running bubbles
   logic w_bubble;
   logic w_latch;
   assign w_bubble = bus.flush | (bus.stall[2] & ~bus.stall[3]);
   assign w_latch  = ~bus.flush & ~bus.stall[2];

   // pipeline registers
   logic [31:0]           r_debug_pc;
   logic [REG_ADDR_W-1:0] r_waddr;
   logic                  r_we;
   logic [31:0]           r_wdata;
   logic [ALUOP_W-1:0]    r_aluop;
   logic [ADDR_W-1:0]     r_mem_addr;
   logic [31:0]           r_mem_data;

   // EX/MEM register: bubble, latch or hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_debug_pc <= '0;
         r_waddr    <= '0;
         r_we       <= 1'b0;
         r_wdata    <= '0;
         r_aluop    <= '0;
         r_mem_addr <= '0;
         r_mem_data <= '0;
      end else if (w_bubble) begin
         r_debug_pc <= '0;
         r_waddr    <= '0;
         r_we       <= 1'b0;
         r_wdata    <= '0;
         r_aluop    <= '0;
         r_mem_addr <= '0;
         r_mem_data <= '0;
      end else if (w_latch) begin
         r_debug_pc <= bus.debug_pc_i;
         r_waddr    <= bus.ex_waddr;
         r_we       <= bus.ex_we;
         r_wdata    <= bus.ex_wdata;
         r_aluop    <= bus.ex_aluop;
         r_mem_addr <= bus.ex_mem_addr;
         r_mem_data <= bus.ex_mem_data;
      end
   end

   assign bus.debug_pc_o   = r_debug_pc;
   assign bus.mem_waddr    = r_waddr;
   assign bus.mem_we       = r_we;
   assign bus.mem_wdata    = r_wdata;
   assign bus.mem_aluop    = r_aluop;
   assign bus.mem_mem_addr = r_mem_addr;
   assign bus.mem_mem_data = r_mem_data;

   // store alignment: build the lane mask and lane-positioned data
   logic        w_align_ok;
   logic [3:0]  w_st_mask;
   logic [31:0] w_st_data;
   logic [1:0]  w_lane;
   assign w_lane = bus.ex_mem_addr[1:0];

   // decode size and offset into mask/data; reserved size never aligns
   always_comb begin
      w_align_ok = 1'b0;
      w_st_mask  = 4'b0000;
      w_st_data  = 32'h0;
      case (bus.ex_store_size)
         2'b00: begin
            w_align_ok = 1'b1;
            w_st_mask  = 4'b0001 << w_lane;
            w_st_data  = {24'h0, bus.ex_mem_data[7:0]} << {w_lane, 3'b000};
         end
         2'b01: begin
            w_align_ok = ~w_lane[0];
            w_st_mask  = w_lane[1] ? 4'b1100 : 4'b0011;
            w_st_data  = w_lane[1] ? {bus.ex_mem_data[15:0], 16'h0}
                                   : {16'h0, bus.ex_mem_data[15:0]};
         end
         2'b10: begin
            w_align_ok = (w_lane == 2'b00);
            w_st_mask  = 4'b1111;
            w_st_data  = bus.ex_mem_data;
         end
         default: begin
            w_align_ok = 1'b0;
         end
      endcase
   end

   logic w_push;
   assign w_push = w_latch & bus.ex_store_en & w_align_ok;

   // store-history buffer
   logic [WA_W-1:0]     r_sb_wa   [SB_DEPTH];
   logic [3:0]          r_sb_mask [SB_DEPTH];
   logic [31:0]         r_sb_data [SB_DEPTH];
   logic [SB_DEPTH-1:0] r_sb_valid;
   logic [PTR_W-1:0]    r_wptr;
   logic [CNT_W-1:0]    r_count;

   // valid bits, pointer and occupancy; clear beats a same-cycle push
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sb_valid <= '0;
         r_wptr     <= '0;
         r_count    <= '0;
      end else if (bus.sb_clear) begin
         r_sb_valid <= '0;
         r_wptr     <= '0;
         r_count    <= '0;
      end else if (w_push) begin
         r_sb_valid[r_wptr] <= 1'b1;
         r_wptr             <= r_wptr + 1'b1;
         if (r_count != CNT_W'(SB_DEPTH)) begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   // entry payload; validity alone decides whether an entry is live
   always_ff @(posedge clk) begin
      if (w_push && !bus.sb_clear) begin
         r_sb_wa[r_wptr]   <= bus.ex_mem_addr[ADDR_W-1:2];
         r_sb_mask[r_wptr] <= w_st_mask;
         r_sb_data[r_wptr] <= w_st_data;
      end
   end

   assign bus.sb_count = r_count;

   // forwarding lookup: walk oldest to newest so newer entries overwrite lanes
   logic [PTR_W-1:0] w_idx;
   logic [31:0]      w_fwd_data;
   logic [3:0]       w_fwd_mask;
   always_comb begin
      w_idx      = '0;
      w_fwd_data = 32'h0;
      w_fwd_mask = 4'b0000;
      for (int k = SB_DEPTH; k >= 1; k--) begin
         w_idx = r_wptr - PTR_W'(k);
         if (r_sb_valid[w_idx] && (r_sb_wa[w_idx] == bus.ld_addr[ADDR_W-1:2])) begin
            for (int l = 0; l < 4; l++) begin
               if (r_sb_mask[w_idx][l]) begin
                  w_fwd_data[8*l +: 8] = r_sb_data[w_idx][8*l +: 8];
                  w_fwd_mask[l]        = 1'b1;
               end
            end
         end
      end
   end

   assign bus.fwd_data = w_fwd_data;
   assign bus.fwd_mask = w_fwd_mask;
   assign bus.fwd_hit  = |w_fwd_mask;

   // lookup is word-granular and only two stall bits matter here
   logic w_unused;
   assign w_unused = &{1'b0, bus.ld_addr[1:0], bus.stall[5:4], bus.stall[1:0]};
endmodule

// File: tb/tb_ex_mem_fwd.sv
// tb/tb_ex_mem_fwd.sv - randomized and directed self-checking bench for ex_mem_fwd
module tb_ex_mem_fwd;
   localparam int ADDR_W = 32, REG_ADDR_W = 5, ALUOP_W = 8, SB_DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ex_mem_fwd_if #(.ADDR_W(ADDR_W), .REG_ADDR_W(REG_ADDR_W), .ALUOP_W(ALUOP_W), .SB_DEPTH(SB_DEPTH)) bus ();

   ex_mem_fwd #(.ADDR_W(ADDR_W), .REG_ADDR_W(REG_ADDR_W), .ALUOP_W(ALUOP_W), .SB_DEPTH(SB_DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model: pipeline view plus a history list of stores, newest last
   typedef struct {
      logic [29:0]      wa;
      logic [3:0]       m;
      logic [3:0][7:0]  b;
   } ent_t;
   ent_t q[$];
   logic [31:0] m_pc, m_wdata, m_maddr, m_mdata;
   logic [4:0]  m_waddr;
   logic        m_we;
   logic [7:0]  m_aluop;

   task automatic model_reset();
      q.delete();
      m_pc = 0; m_wdata = 0; m_maddr = 0; m_mdata = 0; m_waddr = 0; m_we = 0; m_aluop = 0;
   endtask

   task automatic model_edge();
      logic latch, ok;
      ent_t e;
      latch = !bus.flush && !bus.stall[2];
      if (bus.flush || (bus.stall[2] && !bus.stall[3])) begin
         m_pc = 0; m_wdata = 0; m_maddr = 0; m_mdata = 0; m_waddr = 0; m_we = 0; m_aluop = 0;
      end else if (latch) begin
         m_pc = bus.debug_pc_i; m_waddr = bus.ex_waddr; m_we = bus.ex_we; m_wdata = bus.ex_wdata;
         m_aluop = bus.ex_aluop; m_maddr = bus.ex_mem_addr; m_mdata = bus.ex_mem_data;
      end
      e.wa = bus.ex_mem_addr[31:2];
      e.m  = 4'b0000;
      e.b  = '0;
      ok   = 1'b0;
      case (bus.ex_store_size)
         2'd0: begin
            ok = 1'b1;
            e.m[bus.ex_mem_addr[1:0]] = 1'b1;
            e.b[bus.ex_mem_addr[1:0]] = bus.ex_mem_data[7:0];
         end
         2'd1: if (bus.ex_mem_addr[0] == 1'b0) begin
            ok = 1'b1;
            e.m[bus.ex_mem_addr[1]*2]     = 1'b1;
            e.m[bus.ex_mem_addr[1]*2 + 1] = 1'b1;
            e.b[bus.ex_mem_addr[1]*2]     = bus.ex_mem_data[7:0];
            e.b[bus.ex_mem_addr[1]*2 + 1] = bus.ex_mem_data[15:8];
         end
         2'd2: if (bus.ex_mem_addr[1:0] == 2'b00) begin
            ok  = 1'b1;
            e.m = 4'b1111;
            for (int l = 0; l < 4; l++) e.b[l] = bus.ex_mem_data[8*l +: 8];
         end
         default: ok = 1'b0;
      endcase
      if (bus.sb_clear) begin
         q.delete();
      end else if (latch && bus.ex_store_en && ok) begin
         q.push_back(e);
         if (q.size() > SB_DEPTH) void'(q.pop_front());
      end
   endtask

   task automatic model_look(input logic [31:0] a, output logic [31:0] d, output logic [3:0] m);
      d = 0;
      m = 0;
      for (int l = 0; l < 4; l++) begin
         for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].wa == a[31:2] && q[i].m[l]) begin
               d[8*l +: 8] = q[i].b[l];
               m[l] = 1'b1;
               break;
            end
         end
      end
   endtask

   task automatic check_all();
      logic [31:0] d;
      logic [3:0]  m;
      chk("debug_pc", bus.debug_pc_o, m_pc);
      chk("mem_waddr", 32'(bus.mem_waddr), 32'(m_waddr));
      chk("mem_we", 32'(bus.mem_we), 32'(m_we));
      chk("mem_wdata", bus.mem_wdata, m_wdata);
      chk("mem_aluop", 32'(bus.mem_aluop), 32'(m_aluop));
      chk("mem_mem_addr", bus.mem_mem_addr, m_maddr);
      chk("mem_mem_data", bus.mem_mem_data, m_mdata);
      chk("sb_count", 32'(bus.sb_count), q.size());
      model_look(bus.ld_addr, d, m);
      chk("fwd_data", bus.fwd_data, d);
      chk("fwd_mask", 32'(bus.fwd_mask), 32'(m));
      chk("fwd_hit", 32'(bus.fwd_hit), 32'(|m));
   endtask

   task automatic look(input logic [31:0] a);
      bus.ld_addr = a;
      #1;
      check_all();
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic idle();
      bus.stall = 6'b0; bus.flush = 0; bus.sb_clear = 0;
      bus.ex_store_en = 0; bus.ex_store_size = 2'd0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
      bus.ex_mem_addr = a; bus.ex_mem_data = d; bus.ex_store_size = sz; bus.ex_store_en = 1;
      bus.debug_pc_i = $urandom; bus.ex_waddr = 5'($urandom); bus.ex_we = 1'($urandom);
      bus.ex_wdata = $urandom; bus.ex_aluop = 8'($urandom);
      cycle();
      bus.ex_store_en = 0;
   endtask

   initial begin
      idle();
      bus.debug_pc_i = 0; bus.ex_waddr = 0; bus.ex_we = 0; bus.ex_wdata = 0; bus.ex_aluop = 0;
      bus.ex_mem_addr = 0; bus.ex_mem_data = 0; bus.ld_addr = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      rst = 1'b0;

      // pipeline control
      bus.ex_waddr = 5; bus.ex_we = 1; bus.ex_wdata = 32'h1234;
      cycle();
      chk("pipe_latch_waddr", 32'(bus.mem_waddr), 5);
      chk("pipe_latch_wdata", bus.mem_wdata, 32'h1234);
      bus.stall = 6'b000100;
      cycle();
      chk("pipe_bubble_we", 32'(bus.mem_we), 0);
      bus.stall = 6'b000000;
      cycle();
      bus.stall = 6'b001100; bus.ex_wdata = 32'h9999; bus.ex_waddr = 7;
      cycle();
      chk("pipe_hold_wdata", bus.mem_wdata, 32'h1234);
      bus.flush = 1;
      cycle();
      chk("pipe_flush_we", 32'(bus.mem_we), 0);
      idle();

      // byte merge
      store(32'h100, 32'hAABBCCDD, 2'd2);
      store(32'h102, 32'h11, 2'd0);
      look(32'h103);
      chk("merge_data", bus.fwd_data, 32'hAA11CCDD);
      chk("merge_mask", 32'(bus.fwd_mask), 32'hF);

      // partial coverage and misaligned half
      store(32'h202, 32'h5566, 2'd1);
      look(32'h200);
      chk("partial_data", bus.fwd_data, 32'h55660000);
      chk("partial_mask", 32'(bus.fwd_mask), 32'hC);
      chk("partial_hit", 32'(bus.fwd_hit), 1);
      store(32'h201, 32'h7788, 2'd1);
      chk("misalign_count", 32'(bus.sb_count), 3);

      // wrap and overwrite
      for (int i = 0; i < 5; i++) store(32'h10 + 4 * i, $urandom, 2'd2);
      chk("wrap_count", 32'(bus.sb_count), SB_DEPTH);
      look(32'h10);
      chk("wrap_old_hit", 32'(bus.fwd_hit), 0);
      look(32'h20);
      chk("wrap_new_mask", 32'(bus.fwd_mask), 32'hF);

      // clear beats push; stalled store does not push
      bus.sb_clear = 1;
      store(32'h300, 32'hDEADBEEF, 2'd2);
      bus.sb_clear = 0;
      chk("clear_count", 32'(bus.sb_count), 0);
      look(32'h300);
      chk("clear_hit", 32'(bus.fwd_hit), 0);
      bus.stall = 6'b000100;
      store(32'h304, 32'hCAFEF00D, 2'd2);
      bus.stall = 6'b000000;
      chk("stall_nopush", 32'(bus.sb_count), 0);

      // asynchronous reset mid-stream
      store(32'h400, 32'h01020304, 2'd2);
      store(32'h404, 32'h05060708, 2'd2);
      bus.ld_addr = 32'h400;
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_all();
      chk("rst_count", 32'(bus.sb_count), 0);
      chk("rst_hit", 32'(bus.fwd_hit), 0);
      chk("rst_we", 32'(bus.mem_we), 0);
      #1;
      rst = 1'b0;

      // randomized traffic in a small address window so entries collide
      for (int n = 0; n < 400; n++) begin
         bus.stall         = 6'($urandom) & 6'b110011;
         bus.stall[2]      = ($urandom_range(0, 3) == 0);
         bus.stall[3]      = ($urandom_range(0, 3) == 0);
         bus.flush         = ($urandom_range(0, 15) == 0);
         bus.sb_clear      = ($urandom_range(0, 31) == 0);
         bus.ex_store_en   = 1'($urandom);
         bus.ex_store_size = 2'($urandom);
         bus.ex_mem_addr   = 32'h40 + $urandom_range(0, 31);
         bus.ex_mem_data   = $urandom;
         bus.debug_pc_i    = $urandom;
         bus.ex_waddr      = 5'($urandom);
         bus.ex_we         = 1'($urandom);
         bus.ex_wdata      = $urandom;
         bus.ex_aluop      = 8'($urandom);
         bus.ld_addr       = 32'h40 + $urandom_range(0, 31);
         cycle();
         if ((n % 4) == 0) look(32'h40 + $urandom_range(0, 31));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
